calc_issue_sched: RTL
=====================

// Module: calc_issue_sched
// PURPOSE
//   Scheduler and sequencer for the fixed-latency y = a*b*cos(c)/(a+d) datapath.
//   - Arbitrates N requesters round-robin onto the single datapath.
//   - Tags in-flight operations and returns each result to its owner.
//   - Owns the serial d-load: after reset or on a cfg update it drains the pipe,
//     resets the datapath and shifts d in on dp_e, one bit per cycle, LSB first.
// PARAMETERS
//   N        4     number of requesters (2..8)
//   W        12    operand width for a, b, c, d
//   LAT      6     cycles from operands on dp_a/b/c to the valid result on dp_y; must match datapath
//   D_RESET  12'd0 d value loaded automatically after rst
// PORTS
//   clk          in   1      clock
//   rst          in   1      reset, synchronous, active-high
//   req_valid    in   N      requester i has an operand set
//   req_ready    out  N      one-hot grant; the transfer happens when valid&ready
//   req_a        in   N*W    operand a, slice i = requester i
//   req_b        in   N*W    operand b
//   req_c        in   N*W    operand c
//   cfg_valid    in   1      request to load a new d
//   cfg_d        in   W      new d value
//   cfg_ready    out  1      cfg accepted this cycle
//   rsp_valid    out  1      result valid; no backpressure, always consumed
//   rsp_id       out  log2N  owner of the result
//   rsp_y        out  W+1    result {sign, magnitude}
//   busy         out  1      not in RUN, or any operation in flight
//   dp_rst       out  1      datapath reset
//   dp_e         out  1      serial d bit
//   dp_a         out  W      datapath operand a
//   dp_b         out  W      datapath operand b
//   dp_c         out  W      datapath operand c
//   dp_y         in   W+1    datapath result
// BEHAVIOUR
//   - Reset values: req_ready=0, cfg_ready=0, rsp_valid=0, rsp_id=0, busy=1,
//     dp_rst=1, dp_e=0, dp_a/b/c=0. d_shadow=D_RESET. State=DPRST. RR pointer=0.
//   - State machine:
//     - DPRST: dp_rst=1 for exactly one cycle, bit counter cleared, then LOAD.
//     - LOAD: 12 cycles. In cycle k (k=0..11 after dp_rst falls), dp_e=d_shadow[k].
//       After k=11, one settle cycle is taken, then RUN. No grants in LOAD.
//     - RUN: each cycle at most one grant.
//       - Granted operands are driven combinationally onto dp_a/b/c in the same cycle.
//       - Valid flag and id are pushed into a LAT-deep shift line.
//       - With no grant, dp_a/b/c=0 and a valid=0 bubble is pushed.
//     - DRAIN: entered from RUN on cfg_valid. No grants. Stays until the shift line
//       holds no valid entries, then DPRST.
//   - cfg handling: cfg_ready=1 for one cycle on entry to DRAIN. cfg_d is latched
//     into d_shadow at that point. cfg_valid outside RUN is held off; the requester
//     keeps it asserted.
//   - Simultaneous cfg_valid and req_valid in RUN: cfg wins. No grant that cycle.
//     Operations issued earlier are still retired normally.
//   - Arbitration: the first requester with valid=1 at or after the pointer, wrapping
//     N-1 -> 0, is granted. Pointer becomes (granted+1) mod N. With no grant the
//     pointer holds.
//   - Response: op issued in cycle T -> rsp_valid=1 in cycle T+LAT.
//     - rsp_id = tag of that op; rsp_y = dp_y.
//     - Back-to-back issues give back-to-back responses, 1 per cycle, in issue order.
//   - rst mid-operation: in-flight entries are dropped and no rsp_valid is generated.
//     The sequencer restarts at DPRST and loads D_RESET. A previously loaded cfg d is lost.
//   - Widths: d_shadow is W bits, the bit counter 4 bits (0..11), the shift line
//     LAT x (1 + log2N).
// STRUCTURE
//   - Shared package calc_pkg:
//     - W, YW = W+1, LAT.
//     - typedef state_t {DPRST, LOAD, RUN, DRAIN}.
//     - typedef tag_t, log2N bits.
//   - Sub-module rr_arbiter #(N): inputs req[N] and en; outputs gnt[N] one-hot,
//     gnt_id, and the pointer update.
//   - This module holds the FSM, d shifter, operand mux and tag shift line.
// TESTING
//   1. Reset, D_RESET=12'h0A5: dp_rst high 1 cycle; dp_e over 12 cycles = 1,0,1,0,0,1,0,1,0,0,0,0;
//      no req_ready before RUN.
//   2. Only req0 valid with a=100,b=200,c=0 at cycle T: req_ready[0]=1 at T, rsp_valid at T+6,
//      rsp_id=0, rsp_y equals the golden-model value.
//   3. All 4 requesters valid continuously for 8 cycles: grants 0,1,2,3,0,1,2,3; rsp_id in the same order, one per cycle.
//   4. cfg_valid with cfg_d=12'h003 while 3 ops are in flight: those 3 responses arrive, then dp_rst, then dp_e=1,1,0..0,
//      then RUN; the next op uses d=3.
//   5. cfg_valid and req_valid[2] in the same cycle: cfg_ready=1, req_ready=0, req2 granted after reload.
//   6. rst asserted 2 cycles after an issue: no rsp_valid for it; the sequence restarts as in scenario 1.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared constants and types for the y = a*b*cos(c)/(a+d) issue scheduler.
package calc_pkg;

   localparam int DP_W   = 12;
   localparam int DP_YW  = DP_W + 1;
   localparam int DP_LAT = 6;
   localparam int DP_N   = 4;

   typedef enum logic [1:0] {
      DPRST,
      LOAD,
      RUN,
      DRAIN
   } state_t;

   typedef logic [$clog2(DP_N)-1:0] tag_t;

   // Requester id width; a single requester still needs one bit.
   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant for the first requester at or after ptr.
module rr_arbiter #(
   parameter int N   = 4,
   parameter int IDW = 2
) (
   input  logic [N-1:0]   req,
   input  logic           en,
   input  logic [IDW-1:0] ptr,
   output logic [N-1:0]   gnt,
   output logic [IDW-1:0] gnt_id,
   output logic [IDW-1:0] ptr_next
);

   always_comb begin
      int   idx;
      logic found;
      gnt      = '0;
      gnt_id   = '0;
      ptr_next = ptr;
      found    = 1'b0;
      idx      = 0;
      for (int off = 0; off < N; off++) begin
         idx = int'(ptr) + off;
         if (idx >= N) begin
            idx = idx - N;
         end
         if (en && !found && req[idx]) begin
            found    = 1'b1;
            gnt[idx] = 1'b1;
            gnt_id   = IDW'(idx);
            ptr_next = (idx == N - 1) ? '0 : IDW'(idx + 1);
         end
      end
   end

endmodule

// File: rtl/calc_issue_sched.sv
// Issue scheduler for the fixed-latency a*b*cos(c)/(a+d) datapath: arbitration,
// result tagging, and the serial d-load sequence (reset, shift LSB first, settle).
module calc_issue_sched
   import calc_pkg::*;
#(
   parameter int             N       = DP_N,
   parameter int             W       = DP_W,
   parameter int             LAT     = DP_LAT,
   parameter logic [W-1:0]   D_RESET = '0,
   localparam int            IDW     = id_width(N)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     req_valid,
   output logic [N-1:0]     req_ready,
   input  logic [N*W-1:0]   req_a,
   input  logic [N*W-1:0]   req_b,
   input  logic [N*W-1:0]   req_c,
   input  logic             cfg_valid,
   input  logic [W-1:0]     cfg_d,
   output logic             cfg_ready,
   output logic             rsp_valid,
   output logic [IDW-1:0]   rsp_id,
   output logic [W:0]       rsp_y,
   output logic             busy,
   output logic             dp_rst,
   output logic             dp_e,
   output logic [W-1:0]     dp_a,
   output logic [W-1:0]     dp_b,
   output logic [W-1:0]     dp_c,
   input  logic [W:0]       dp_y
);

   localparam int CW = $clog2(W);

   state_t                    state_q, state_d;
   logic [W-1:0]              d_shadow_q, d_shadow_d;
   logic [CW-1:0]             bit_cnt_q, bit_cnt_d;
   logic                      settle_q, settle_d;
   logic [IDW-1:0]            ptr_q, ptr_d;
   logic [LAT-1:0]            vld_q, vld_d;
   logic [LAT-1:0][IDW-1:0]   tag_q, tag_d;

   logic                      arb_en;
   logic [N-1:0]              gnt;
   logic [IDW-1:0]            gnt_id;
   logic [IDW-1:0]            arb_ptr_next;

   rr_arbiter #(
      .N   (N),
      .IDW (IDW)
   ) u_arb (
      .req      (req_valid),
      .en       (arb_en),
      .ptr      (ptr_q),
      .gnt      (gnt),
      .gnt_id   (gnt_id),
      .ptr_next (arb_ptr_next)
   );

   // Sequencer: DPRST -> LOAD (W bits + settle) -> RUN, and RUN -> DRAIN on cfg.
   always_comb begin
      state_d    = state_q;
      d_shadow_d = d_shadow_q;
      bit_cnt_d  = bit_cnt_q;
      settle_d   = settle_q;
      cfg_ready  = 1'b0;
      arb_en     = 1'b0;
      dp_rst     = 1'b0;
      dp_e       = 1'b0;
      case (state_q)
         DPRST: begin
            dp_rst    = 1'b1;
            bit_cnt_d = '0;
            settle_d  = 1'b0;
            state_d   = LOAD;
         end
         LOAD: begin
            if (!settle_q) begin
               dp_e = d_shadow_q[bit_cnt_q];
               if (bit_cnt_q == CW'(W - 1)) begin
                  settle_d = 1'b1;
               end else begin
                  bit_cnt_d = bit_cnt_q + CW'(1);
               end
            end else begin
               settle_d = 1'b0;
               state_d  = RUN;
            end
         end
         RUN: begin
            // A pending cfg takes the cycle; no operand is issued alongside it.
            if (cfg_valid) begin
               cfg_ready  = 1'b1;
               d_shadow_d = cfg_d;
               state_d    = DRAIN;
            end else begin
               arb_en = 1'b1;
            end
         end
         DRAIN: begin
            if (!(|vld_q)) begin
               state_d = DPRST;
            end
         end
         default: state_d = DPRST;
      endcase
   end

   always_comb begin
      ptr_d = arb_ptr_next;
      dp_a  = '0;
      dp_b  = '0;
      dp_c  = '0;
      for (int i = 0; i < N; i++) begin
         if (gnt[i]) begin
            dp_a = req_a[i*W +: W];
            dp_b = req_b[i*W +: W];
            dp_c = req_c[i*W +: W];
         end
      end
   end

   // Tag line tracks the datapath pipe stage by stage; bubbles carry valid=0.
   always_comb begin
      vld_d    = vld_q;
      tag_d    = tag_q;
      vld_d[0] = |gnt;
      tag_d[0] = gnt_id;
      for (int i = 1; i < LAT; i++) begin
         vld_d[i] = vld_q[i-1];
         tag_d[i] = tag_q[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= DPRST;
         d_shadow_q <= D_RESET;
         bit_cnt_q  <= '0;
         settle_q   <= 1'b0;
         ptr_q      <= '0;
         vld_q      <= '0;
         tag_q      <= '0;
      end else begin
         state_q    <= state_d;
         d_shadow_q <= d_shadow_d;
         bit_cnt_q  <= bit_cnt_d;
         settle_q   <= settle_d;
         ptr_q      <= ptr_d;
         vld_q      <= vld_d;
         tag_q      <= tag_d;
      end
   end

   assign req_ready = gnt;
   assign rsp_valid = vld_q[LAT-1];
   assign rsp_id    = tag_q[LAT-1];
   assign rsp_y     = dp_y;
   assign busy      = (state_q != RUN) || (|vld_q);

endmodule
